// File: rtl/alu_regfile_mc.sv
// alu_regfile_mc: multi-cycle ALU (iterative shift-add multiply, single-cycle
// for everything else) with an NREGS-entry result register file and an
// independent combinational read port.
module alu_regfile_mc #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           ctrl,
  input  logic                 reg_write,
  input  logic [AW-1:0]        reg_addr,
  input  logic [AW-1:0]        rd_addr,
  output logic [2*WIDTH-1:0]   y,
  output logic                 c,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   reg_data
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [WIDTH-1:0]       a_reg;
  logic [WIDTH-1:0]       b_reg;
  logic [2:0]             op_reg;
  logic                   we_reg;
  logic [AW-1:0]          waddr_reg;
  logic [2*WIDTH-1:0]     y_reg;
  logic                   c_reg;
  logic                   done_reg;

  // Shift-add multiplier state: accumulator, left-shifting multiplicand,
  // right-shifting multiplier and remaining-bit counter.
  logic [2*WIDTH-1:0]     acc_reg;
  logic [2*WIDTH-1:0]     mcand_reg;
  logic [WIDTH-1:0]       mplier_reg;
  logic [CW-1:0]          cnt_reg;

  logic [2*WIDTH-1:0]     regs [NREGS];

  logic [WIDTH:0]         sum;
  logic [WIDTH-1:0]       diff_lo;
  logic [2*WIDTH-1:0]     a_ext;
  logic [2*WIDTH-1:0]     acc_next;
  logic [2*WIDTH-1:0]     result;
  logic                   carry;
  logic                   finish;
  logic                   wr_en;

  // Result datapath working from the latched operands; for MUL the result is
  // the accumulator after adding in the current multiplier bit.
  always_comb begin
    sum      = {1'b0, a_reg} + {1'b0, b_reg};
    diff_lo  = a_reg - b_reg;
    a_ext    = {{WIDTH{1'b0}}, a_reg};
    acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    result   = '0;
    carry    = 1'b0;
    case (op_reg)
      OP_ADD: begin
        result = {{(WIDTH-1){1'b0}}, sum};
        carry  = sum[WIDTH];
      end
      OP_SUB: begin
        result = {{WIDTH{1'b0}}, diff_lo};
        carry  = (a_reg < b_reg);
      end
      OP_AND: result = {{WIDTH{1'b0}}, a_reg & b_reg};
      OP_OR:  result = {{WIDTH{1'b0}}, a_reg | b_reg};
      OP_XOR: result = {{WIDTH{1'b0}}, a_reg ^ b_reg};
      OP_MUL: result = acc_next;
      OP_SHL: result = a_ext << b_reg;
      OP_SHR: result = a_ext >> b_reg;
      default: result = '0;
    endcase
    finish = (op_reg != OP_MUL) || (cnt_reg == CW'(1));
    wr_en  = (state_reg == EXEC) && finish && we_reg;
  end

  // Control FSM: latch request in IDLE, iterate in EXEC, pulse done in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= OP_ADD;
      we_reg     <= 1'b0;
      waddr_reg  <= '0;
      y_reg      <= '0;
      c_reg      <= 1'b0;
      done_reg   <= 1'b0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            a_reg      <= a;
            b_reg      <= b;
            op_reg     <= ctrl;
            we_reg     <= reg_write;
            waddr_reg  <= reg_addr;
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
            cnt_reg    <= CW'(WIDTH);
            state_reg  <= EXEC;
          end
        end
        EXEC: begin
          if (op_reg == OP_MUL) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg - CW'(1);
          end
          if (finish) begin
            y_reg     <= result;
            c_reg     <= carry;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Register file: written with the final result on the edge that enters DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[waddr_reg] <= result;
    end
  end

  assign y        = y_reg;
  assign c        = c_reg;
  assign done     = done_reg;
  assign busy     = (state_reg != IDLE);
  assign reg_data = regs[rd_addr];

endmodule

// File: tb/tb_alu_regfile_mc.sv
// Scoreboard bench for alu_regfile_mc (WIDTH=4, NREGS=4).
module tb_alu_regfile_mc;
  localparam int W = 4;
  localparam int N = 4;
  localparam int A = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2:0]     ctrl = '0;
  logic           reg_write = 1'b0;
  logic [A-1:0]   reg_addr = '0;
  logic [A-1:0]   rd_addr = '0;
  logic [2*W-1:0] y;
  logic           c;
  logic           busy;
  logic           done;
  logic [2*W-1:0] reg_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2*W-1:0] y;
    logic           c;
    logic           we;
    logic [A-1:0]   ad;
  } exp_t;

  exp_t           exp_q[$];
  logic [2*W-1:0] model_regs [N];

  alu_regfile_mc #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ctrl(ctrl),
    .reg_write(reg_write), .reg_addr(reg_addr), .rd_addr(rd_addr),
    .y(y), .c(c), .busy(busy), .done(done), .reg_data(reg_data)
  );

  always #5 clk = ~clk;

  // Reference arithmetic using plain integer math.
  function automatic exp_t model_op(input logic [2:0] op, input int unsigned av,
                                    input int unsigned bv);
    exp_t r;
    int unsigned t;
    int unsigned mlo;
    int unsigned mfull;
    mlo   = (1 << W) - 1;
    mfull = (1 << (2 * W)) - 1;
    r = '0;
    t = 0;
    case (op)
      3'd0: begin t = av + bv; r.c = ((t >> W) & 1) != 0; end
      3'd1: begin t = (av - bv) & mlo; r.c = (av < bv); end
      3'd2: t = av & bv;
      3'd3: t = av | bv;
      3'd4: t = av ^ bv;
      3'd5: t = av * bv;
      3'd6: t = (bv >= 2 * W) ? 0 : ((av << bv) & mfull);
      default: t = av >> bv;
    endcase
    r.y = t[2*W-1:0];
    return r;
  endfunction

  // Drive one start pulse; returns at the negedge after the sampling edge.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic we,
                          input logic [A-1:0] ad);
    exp_t e;
    @(negedge clk);
    ctrl = op; a = av; b = bv; reg_write = we; reg_addr = ad; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    e = model_op(op, 32'(av), 32'(bv));
    e.we = we;
    e.ad = ad;
    exp_q.push_back(e);
  endtask

  // Follow an operation until busy drops, recording latency and pulse counts.
  task automatic wait_done(output int lat, output int dcnt, output int bcnt,
                           output logic [2*W-1:0] yv, output logic cv);
    lat = -1; dcnt = 0; bcnt = busy ? 1 : 0; yv = 'x; cv = 1'bx;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (lat < 0) begin lat = i; yv = y; cv = c; end
      end
      if (busy) bcnt++;
      else break;
    end
  endtask

  task automatic read_reg(input logic [A-1:0] ad, output logic [2*W-1:0] v);
    @(negedge clk);
    rd_addr = ad;
    #1 v = reg_data;
  endtask

  task automatic test_reset();
    logic [2*W-1:0] v;
    repeat (2) @(negedge clk);
    n_checks++;
    if (y !== '0 || c !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: y=%h c=%b busy=%b done=%b, required 0", y, c, busy, done);
    end
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      model_regs[i] = '0;
      read_reg(A'(i), v);
      n_checks++;
      if (v !== '0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h, required 00", i, v);
      end
    end
    $display("reset released");
  endtask

  task automatic test_add();
    int lat, dcnt, bcnt; logic [2*W-1:0] yv, v; logic cv; exp_t e;
    start_op(3'b000, 4'd9, 4'd8, 1'b1, 2'd0);
    wait_done(lat, dcnt, bcnt, yv, cv);
    e = exp_q.pop_front();
    if (e.we) model_regs[e.ad] = e.y;
    $display("ADD a=9 b=8 y=%h c=%b lat=%0d", yv, cv, lat);
    n_checks++;
    if (lat != 1 || dcnt != 1 || bcnt != 2) begin
      n_fail++;
      $display("FAIL add_timing: lat=%0d done=%0d busy=%0d, required 1/1/2", lat, dcnt, bcnt);
    end
    n_checks++;
    if (yv !== e.y || cv !== e.c) begin
      n_fail++;
      $display("FAIL add_result: y=%h c=%b, required y=%h c=%b", yv, cv, e.y, e.c);
    end
    read_reg(2'd0, v);
    n_checks++;
    if (v !== model_regs[0]) begin
      n_fail++;
      $display("FAIL add_reg0: got %h, required %h", v, model_regs[0]);
    end
  endtask

  task automatic test_sub();
    int lat, dcnt, bcnt; logic [2*W-1:0] yv, v; logic cv; exp_t e;
    logic [W-1:0] av [2];
    logic [W-1:0] bv [2];
    av[0] = 4'd3; bv[0] = 4'd1; av[1] = 4'd1; bv[1] = 4'd3;
    for (int t = 0; t < 2; t++) begin
      start_op(3'b001, av[t], bv[t], t == 1, 2'd1);
      wait_done(lat, dcnt, bcnt, yv, cv);
      e = exp_q.pop_front();
      if (e.we) model_regs[e.ad] = e.y;
      $display("SUB a=%0d b=%0d y=%h c=%b lat=%0d", av[t], bv[t], yv, cv, lat);
      n_checks++;
      if (yv !== e.y || cv !== e.c || lat != 1) begin
        n_fail++;
        $display("FAIL sub_result%0d: y=%h c=%b lat=%0d, required y=%h c=%b lat=1",
                 t, yv, cv, lat, e.y, e.c);
      end
    end
    for (int i = 0; i < 2; i++) begin
      read_reg(A'(i), v);
      n_checks++;
      if (v !== model_regs[i]) begin
        n_fail++;
        $display("FAIL sub_reg%0d: got %h, required %h", i, v, model_regs[i]);
      end
    end
  endtask

  task automatic test_mul();
    int lat, dcnt, bcnt; logic [2*W-1:0] yv, v; logic cv; exp_t e;
    start_op(3'b101, 4'd15, 4'd15, 1'b1, 2'd2);
    wait_done(lat, dcnt, bcnt, yv, cv);
    e = exp_q.pop_front();
    if (e.we) model_regs[e.ad] = e.y;
    $display("MUL a=15 b=15 y=%h c=%b lat=%0d busy=%0d", yv, cv, lat, bcnt);
    n_checks++;
    if (lat != W || dcnt != 1 || bcnt != W + 1) begin
      n_fail++;
      $display("FAIL mul_timing: lat=%0d done=%0d busy=%0d, required %0d/1/%0d",
               lat, dcnt, bcnt, W, W + 1);
    end
    n_checks++;
    if (yv !== e.y || cv !== e.c) begin
      n_fail++;
      $display("FAIL mul_result: y=%h c=%b, required y=%h c=%b", yv, cv, e.y, e.c);
    end
    read_reg(2'd2, v);
    n_checks++;
    if (v !== model_regs[2]) begin
      n_fail++;
      $display("FAIL mul_reg2: got %h, required %h", v, model_regs[2]);
    end
  endtask

  task automatic test_logic_shift();
    int lat, dcnt, bcnt; logic [2*W-1:0] yv, v; logic cv; exp_t e;
    logic [2:0] ops [5];
    ops[0] = 3'b010; ops[1] = 3'b011; ops[2] = 3'b100; ops[3] = 3'b110; ops[4] = 3'b111;
    for (int t = 0; t < 5; t++) begin
      start_op(ops[t], 4'b1010, 4'b0011, 1'b0, A'(t));
      wait_done(lat, dcnt, bcnt, yv, cv);
      e = exp_q.pop_front();
      $display("OP%0d a=1010 b=0011 y=%h c=%b lat=%0d", ops[t], yv, cv, lat);
      n_checks++;
      if (yv !== e.y || cv !== e.c || lat != 1) begin
        n_fail++;
        $display("FAIL logic_op%0d: y=%h c=%b lat=%0d, required y=%h c=%b lat=1",
                 ops[t], yv, cv, lat, e.y, e.c);
      end
    end
    for (int i = 0; i < N; i++) begin
      read_reg(A'(i), v);
      n_checks++;
      if (v !== model_regs[i]) begin
        n_fail++;
        $display("FAIL logic_reg%0d: got %h, required %h", i, v, model_regs[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat, dcnt, bcnt, extra; logic [2*W-1:0] yv, v; logic cv; exp_t e;
    start_op(3'b101, 4'd15, 4'd15, 1'b0, 2'd2);
    ctrl = 3'b000; a = 4'd1; b = 4'd1; reg_write = 1'b1; reg_addr = 2'd3; start = 1'b1;
    fork
      begin @(posedge clk); @(negedge clk); start = 1'b0; end
    join_none
    wait_done(lat, dcnt, bcnt, yv, cv);
    e = exp_q.pop_front();
    $display("MUL+ignored ADD y=%h c=%b lat=%0d done=%0d", yv, cv, lat, dcnt);
    n_checks++;
    if (yv !== e.y || cv !== e.c || lat != W || dcnt != 1) begin
      n_fail++;
      $display("FAIL ignore_start: y=%h c=%b lat=%0d done=%0d, required y=%h c=%b lat=%0d done=1",
               yv, cv, lat, dcnt, e.y, e.c, W);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    n_checks++;
    if (extra != 0 || y !== e.y) begin
      n_fail++;
      $display("FAIL ignore_no_retrigger: activity=%0d y=%h, required 0 and y=%h", extra, y, e.y);
    end
    read_reg(2'd3, v);
    n_checks++;
    if (v !== model_regs[3]) begin
      n_fail++;
      $display("FAIL ignore_reg3: got %h, required %h", v, model_regs[3]);
    end
  endtask

  task automatic test_reset_mid_mul();
    int dcnt, bcnt; logic [2*W-1:0] v;
    start_op(3'b101, 4'd15, 4'd15, 1'b1, 2'd3);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) model_regs[i] = '0;
    #1;
    n_checks++;
    if (y !== '0 || c !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: y=%h c=%b busy=%b done=%b, required 0", y, c, busy, done);
    end
    @(negedge clk);
    reset = 1'b1;
    dcnt = 0; bcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    $display("mid-MUL reset: done pulses=%0d busy cycles=%0d", dcnt, bcnt);
    n_checks++;
    if (dcnt != 0 || bcnt != 0) begin
      n_fail++;
      $display("FAIL midreset_activity: done=%0d busy=%0d, required 0/0", dcnt, bcnt);
    end
    for (int i = 0; i < N; i++) begin
      read_reg(A'(i), v);
      n_checks++;
      if (v !== model_regs[i]) begin
        n_fail++;
        $display("FAIL midreset_reg%0d: got %h, required %h", i, v, model_regs[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_logic_shift();
    test_start_ignored();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
